// File: rtl/itch_order_decode_bank.sv
// itch_order_decode_bank
//
// Byte-serial decoder for ITCH 5.0 Add Order ('A'), Order Cancel ('X') and
// Order Delete ('D') messages. One byte is consumed per clock. All three
// decoders capture their fields speculatively at their own byte offsets, and
// the type byte selects which decoder reports completion or truncation.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   byte_in, valid_in        message byte stream; a low valid_in ends a message
//   add_*                    Add Order pulses and fields
//   cancel_*                 Order Cancel pulses and fields
//   delete_*                 Order Delete pulses and fields
// *_internal_valid pulses one cycle after the final byte of a complete message.
// *_packet_invalid pulses one cycle after valid_in drops mid-message.
// Field outputs hold their value until the next message overwrites them.

module itch_order_decode_bank (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_in,
    input  logic        valid_in,
    output logic        add_internal_valid,
    output logic        add_packet_invalid,
    output logic [63:0] add_order_ref,
    output logic        add_side,
    output logic [31:0] add_shares,
    output logic [63:0] add_stock_symbol,
    output logic [31:0] add_price,
    output logic        cancel_internal_valid,
    output logic        cancel_packet_invalid,
    output logic [63:0] cancel_order_ref,
    output logic [31:0] cancel_canceled_shares,
    output logic        delete_internal_valid,
    output logic        delete_packet_invalid,
    output logic [63:0] delete_order_ref
);

    localparam logic [7:0] TYPE_ADD    = 8'h41;
    localparam logic [7:0] TYPE_CANCEL = 8'h58;
    localparam logic [7:0] TYPE_DELETE = 8'h44;
    localparam logic [7:0] SIDE_SELL   = 8'h53;

    localparam logic [5:0] LAST_ADD    = 6'd35;
    localparam logic [5:0] LAST_CANCEL = 6'd22;
    localparam logic [5:0] LAST_DELETE = 6'd18;
    localparam logic [5:0] IDX_MAX     = 6'd63;

    logic [5:0] idx;
    logic [7:0] msg_type;

    logic is_add;
    logic is_cancel;
    logic is_delete;
    logic add_last;
    logic cancel_last;
    logic delete_last;
    logic msg_done;
    logic in_msg;

    // msg_type is only trusted once idx > 0; at idx 0 the incoming byte is
    // the new type, and no final-byte index is 0, so a stale type is harmless.
    always_comb begin
        is_add      = (msg_type == TYPE_ADD);
        is_cancel   = (msg_type == TYPE_CANCEL);
        is_delete   = (msg_type == TYPE_DELETE);
        add_last    = valid_in && is_add    && (idx == LAST_ADD);
        cancel_last = valid_in && is_cancel && (idx == LAST_CANCEL);
        delete_last = valid_in && is_delete && (idx == LAST_DELETE);
        msg_done    = add_last || cancel_last || delete_last;
        in_msg      = (idx != 6'd0);
    end

    // ---- byte counter and type register ----
    // Unknown types never hit a final index, so idx climbs and parks at
    // IDX_MAX until valid_in drops; beyond index 35 no field is written.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= 6'd0;
            msg_type <= 8'd0;
        end else if (!valid_in) begin
            idx <= 6'd0;
        end else begin
            if (idx == 6'd0) begin
                msg_type <= byte_in;
            end
            if (msg_done) begin
                idx <= 6'd0;
            end else if (idx != IDX_MAX) begin
                idx <= idx + 6'd1;
            end
        end
    end

    // ---- registered pulses and speculative field capture ----
    always_ff @(posedge clk) begin
        if (rst) begin
            add_internal_valid     <= 1'b0;
            add_packet_invalid     <= 1'b0;
            add_order_ref          <= 64'd0;
            add_side               <= 1'b0;
            add_shares             <= 32'd0;
            add_stock_symbol       <= 64'd0;
            add_price              <= 32'd0;
            cancel_internal_valid  <= 1'b0;
            cancel_packet_invalid  <= 1'b0;
            cancel_order_ref       <= 64'd0;
            cancel_canceled_shares <= 32'd0;
            delete_internal_valid  <= 1'b0;
            delete_packet_invalid  <= 1'b0;
            delete_order_ref       <= 64'd0;
        end else begin
            add_internal_valid    <= add_last;
            cancel_internal_valid <= cancel_last;
            delete_internal_valid <= delete_last;

            // Truncation: type byte already taken (idx > 0) and the stream stops.
            add_packet_invalid    <= !valid_in && in_msg && is_add;
            cancel_packet_invalid <= !valid_in && in_msg && is_cancel;
            delete_packet_invalid <= !valid_in && in_msg && is_delete;

            // Big-endian fields: shift left so the first byte lands in the MSBs.
            if (valid_in) begin
                if (idx >= 6'd11 && idx <= 6'd18) begin
                    add_order_ref    <= {add_order_ref[55:0], byte_in};
                    cancel_order_ref <= {cancel_order_ref[55:0], byte_in};
                    delete_order_ref <= {delete_order_ref[55:0], byte_in};
                end
                if (idx == 6'd19) begin
                    add_side <= (byte_in == SIDE_SELL);
                end
                if (idx >= 6'd20 && idx <= 6'd23) begin
                    add_shares <= {add_shares[23:0], byte_in};
                end
                if (idx >= 6'd24 && idx <= 6'd31) begin
                    add_stock_symbol <= {add_stock_symbol[55:0], byte_in};
                end
                if (idx >= 6'd32 && idx <= 6'd35) begin
                    add_price <= {add_price[23:0], byte_in};
                end
                if (idx >= 6'd19 && idx <= 6'd22) begin
                    cancel_canceled_shares <= {cancel_canceled_shares[23:0], byte_in};
                end
            end
        end
    end

endmodule

// File: tb/tb_itch_order_decode_bank.sv
// Testbench for itch_order_decode_bank: directed vector table, hand-written
// back-to-back / reset sequences, and randomized messages checked every cycle
// against a message-buffer reference model.

`timescale 1ns/1ps

module tb_itch_order_decode_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  byte_in;
    logic        valid_in;
    logic        add_internal_valid;
    logic        add_packet_invalid;
    logic [63:0] add_order_ref;
    logic        add_side;
    logic [31:0] add_shares;
    logic [63:0] add_stock_symbol;
    logic [31:0] add_price;
    logic        cancel_internal_valid;
    logic        cancel_packet_invalid;
    logic [63:0] cancel_order_ref;
    logic [31:0] cancel_canceled_shares;
    logic        delete_internal_valid;
    logic        delete_packet_invalid;
    logic [63:0] delete_order_ref;

    always #5 clk = ~clk;

    itch_order_decode_bank dut (
        .clk                    (clk),
        .rst                    (rst),
        .byte_in                (byte_in),
        .valid_in               (valid_in),
        .add_internal_valid     (add_internal_valid),
        .add_packet_invalid     (add_packet_invalid),
        .add_order_ref          (add_order_ref),
        .add_side               (add_side),
        .add_shares             (add_shares),
        .add_stock_symbol       (add_stock_symbol),
        .add_price              (add_price),
        .cancel_internal_valid  (cancel_internal_valid),
        .cancel_packet_invalid  (cancel_packet_invalid),
        .cancel_order_ref       (cancel_order_ref),
        .cancel_canceled_shares (cancel_canceled_shares),
        .delete_internal_valid  (delete_internal_valid),
        .delete_packet_invalid  (delete_packet_invalid),
        .delete_order_ref       (delete_order_ref)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic int msglen(input logic [7:0] t);
        case (t)
            8'h41:   return 36;
            8'h58:   return 23;
            8'h44:   return 19;
            default: return 0;
        endcase
    endfunction

    // ---------------- reference model ----------------
    // Collects the bytes of the current message; decides at message end.
    logic [7:0]  mbuf[$];
    logic        e_add_ok = 0, e_add_bad = 0, e_can_ok = 0, e_can_bad = 0;
    logic        e_del_ok = 0, e_del_bad = 0, e_zero = 0;
    logic [63:0] e_add_ref = 0, e_stock = 0, e_can_ref = 0, e_del_ref = 0;
    logic [31:0] e_shares = 0, e_price = 0, e_can_sh = 0;
    logic        e_side = 0;

    function automatic logic [63:0] be(input int first, input int n);
        logic [63:0] r;
        r = 64'd0;
        for (int j = 0; j < n; j++) r = {r[55:0], mbuf[first + j]};
        return r;
    endfunction

    always @(posedge clk) begin
        e_add_ok = 0; e_add_bad = 0; e_can_ok = 0; e_can_bad = 0;
        e_del_ok = 0; e_del_bad = 0; e_zero = 0;
        if (rst) begin
            mbuf.delete();
            e_zero = 1;
        end else if (valid_in) begin
            if (mbuf.size() < 64) mbuf.push_back(byte_in);
            if (msglen(mbuf[0]) != 0 && mbuf.size() == msglen(mbuf[0])) begin
                case (mbuf[0])
                    8'h41: begin
                        e_add_ok  = 1;
                        e_add_ref = be(11, 8);
                        e_side    = (mbuf[19] == 8'h53);
                        e_shares  = 32'(be(20, 4));
                        e_stock   = be(24, 8);
                        e_price   = 32'(be(32, 4));
                    end
                    8'h58: begin
                        e_can_ok  = 1;
                        e_can_ref = be(11, 8);
                        e_can_sh  = 32'(be(19, 4));
                    end
                    default: begin
                        e_del_ok  = 1;
                        e_del_ref = be(11, 8);
                    end
                endcase
                mbuf.delete();
            end
        end else begin
            if (mbuf.size() > 0) begin
                case (mbuf[0])
                    8'h41:   e_add_bad = 1;
                    8'h58:   e_can_bad = 1;
                    8'h44:   e_del_bad = 1;
                    default: ;
                endcase
            end
            mbuf.delete();
        end
    end

    // ---------------- per-cycle checker and pulse monitor ----------------
    int          n_ok[3];
    int          n_bad[3];
    logic [63:0] l_add_ref, l_stock, l_can_ref, l_del_ref;
    logic [31:0] l_shares, l_price, l_can_sh;
    logic        l_side;

    always @(posedge clk) begin
        logic [5:0] p;
        #1;
        p = {add_internal_valid, add_packet_invalid, cancel_internal_valid,
             cancel_packet_invalid, delete_internal_valid, delete_packet_invalid};
        chk("pulses", 64'(p), 64'({e_add_ok, e_add_bad, e_can_ok, e_can_bad, e_del_ok, e_del_bad}));
        chk("pulse_onehot", 64'($countones(p) <= 1), 64'd1);
        if (e_zero)
            chk("reset_outputs", 64'(|{p, add_order_ref, add_side, add_shares, add_stock_symbol,
                add_price, cancel_order_ref, cancel_canceled_shares, delete_order_ref}), 64'd0);
        if (e_add_ok) begin
            chk("add_order_ref", add_order_ref, e_add_ref);
            chk("add_side", 64'(add_side), 64'(e_side));
            chk("add_shares", 64'(add_shares), 64'(e_shares));
            chk("add_stock_symbol", add_stock_symbol, e_stock);
            chk("add_price", 64'(add_price), 64'(e_price));
        end
        if (e_can_ok) begin
            chk("cancel_order_ref", cancel_order_ref, e_can_ref);
            chk("cancel_shares", 64'(cancel_canceled_shares), 64'(e_can_sh));
        end
        if (e_del_ok) chk("delete_order_ref", delete_order_ref, e_del_ref);

        if (add_internal_valid) begin
            n_ok[0]++;
            l_add_ref = add_order_ref; l_side = add_side; l_shares = add_shares;
            l_stock = add_stock_symbol; l_price = add_price;
        end
        if (cancel_internal_valid) begin
            n_ok[1]++;
            l_can_ref = cancel_order_ref; l_can_sh = cancel_canceled_shares;
        end
        if (delete_internal_valid) begin
            n_ok[2]++;
            l_del_ref = delete_order_ref;
        end
        if (add_packet_invalid)    n_bad[0]++;
        if (cancel_packet_invalid) n_bad[1]++;
        if (delete_packet_invalid) n_bad[2]++;
    end

    // ---------------- stimulus ----------------
    typedef struct {
        logic [7:0]  typ;
        int          nsend;
        logic [63:0] ord;
        logic        side;
        logic [31:0] shares;
        logic [63:0] stock;
        logic [31:0] price;
        logic [2:0]  exp_ok;   // {add, cancel, delete}
        logic [2:0]  exp_bad;  // {add, cancel, delete}
    } vec_t;

    vec_t       vecs[9];
    logic [7:0] msg[64];

    task automatic build(input vec_t v);
        for (int i = 0; i < 64; i++) msg[i] = 8'($urandom);
        msg[0] = v.typ;
        for (int j = 0; j < 8; j++) msg[11 + j] = v.ord[63 - 8*j -: 8];
        if (v.typ == 8'h41) begin
            msg[19] = v.side ? 8'h53 : 8'h42;
            for (int j = 0; j < 4; j++) msg[20 + j] = v.shares[31 - 8*j -: 8];
            for (int j = 0; j < 8; j++) msg[24 + j] = v.stock[63 - 8*j -: 8];
            for (int j = 0; j < 4; j++) msg[32 + j] = v.price[31 - 8*j -: 8];
        end else if (v.typ == 8'h58) begin
            for (int j = 0; j < 4; j++) msg[19 + j] = v.shares[31 - 8*j -: 8];
        end
    endtask

    task automatic send(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            valid_in = 1'b1;
            byte_in  = msg[i];
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid_in = 1'b0;
            byte_in  = 8'h00;
        end
    endtask

    task automatic clear_counts();
        for (int g = 0; g < 3; g++) begin
            n_ok[g]  = 0;
            n_bad[g] = 0;
        end
    endtask

    task automatic check_counts(input string tag, input logic [2:0] ok, input logic [2:0] bad);
        chk({tag, "_add_ok"},     64'(n_ok[0]),  64'(ok[2]));
        chk({tag, "_cancel_ok"},  64'(n_ok[1]),  64'(ok[1]));
        chk({tag, "_delete_ok"},  64'(n_ok[2]),  64'(ok[0]));
        chk({tag, "_add_bad"},    64'(n_bad[0]), 64'(bad[2]));
        chk({tag, "_cancel_bad"}, 64'(n_bad[1]), 64'(bad[1]));
        chk({tag, "_delete_bad"}, 64'(n_bad[2]), 64'(bad[0]));
    endtask

    task automatic check_fields(input string tag, input vec_t v);
        if (v.exp_ok[2]) begin
            chk({tag, "_add_ref"},   l_add_ref,       v.ord);
            chk({tag, "_add_side"},  64'(l_side),     64'(v.side));
            chk({tag, "_add_shares"}, 64'(l_shares),  64'(v.shares));
            chk({tag, "_add_stock"}, l_stock,         v.stock);
            chk({tag, "_add_price"}, 64'(l_price),    64'(v.price));
        end
        if (v.exp_ok[1]) begin
            chk({tag, "_cancel_ref"},    l_can_ref,      v.ord);
            chk({tag, "_cancel_shares"}, 64'(l_can_sh),  64'(v.shares));
        end
        if (v.exp_ok[0]) chk({tag, "_delete_ref"}, l_del_ref, v.ord);
    endtask

    initial begin
        vec_t v;
        vec_t v2;
        int   sel;
        int   len;
        int   gap;

        vecs[0] = '{typ:8'h41, nsend:36, ord:64'h1, side:1'b1, shares:32'd100,
                    stock:64'h4141504C20202020, price:32'd1500000, exp_ok:3'b100, exp_bad:3'b000};
        vecs[1] = '{typ:8'h58, nsend:23, ord:64'h1122334455667788, side:1'b0, shares:32'h12C,
                    stock:64'h0, price:32'h0, exp_ok:3'b010, exp_bad:3'b000};
        vecs[2] = '{typ:8'h44, nsend:19, ord:64'hDEADBEEF00000042, side:1'b0, shares:32'h0,
                    stock:64'h0, price:32'h0, exp_ok:3'b001, exp_bad:3'b000};
        vecs[3] = '{typ:8'h41, nsend:21, ord:64'h55, side:1'b1, shares:32'd7,
                    stock:64'h4D53465420202020, price:32'd9, exp_ok:3'b000, exp_bad:3'b100};
        vecs[4] = '{typ:8'h58, nsend:1, ord:64'h0, side:1'b0, shares:32'h0,
                    stock:64'h0, price:32'h0, exp_ok:3'b000, exp_bad:3'b010};
        vecs[5] = '{typ:8'h44, nsend:18, ord:64'hFFFFFFFFFFFFFFFF, side:1'b0, shares:32'h0,
                    stock:64'h0, price:32'h0, exp_ok:3'b000, exp_bad:3'b001};
        vecs[6] = '{typ:8'h41, nsend:36, ord:64'h8000000000000001, side:1'b0, shares:32'hFFFFFFFF,
                    stock:64'h474F4F4720202020, price:32'h80000001, exp_ok:3'b100, exp_bad:3'b000};
        vecs[7] = '{typ:8'h5A, nsend:31, ord:64'h0, side:1'b0, shares:32'h0,
                    stock:64'h0, price:32'h0, exp_ok:3'b000, exp_bad:3'b000};
        vecs[8] = '{typ:8'h44, nsend:19, ord:64'h0123456789ABCDEF, side:1'b0, shares:32'h0,
                    stock:64'h0, price:32'h0, exp_ok:3'b001, exp_bad:3'b000};

        rst = 1'b1; valid_in = 1'b0; byte_in = 8'h00;
        clear_counts();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(2);

        // Directed vector table
        for (int i = 0; i < 9; i++) begin
            clear_counts();
            build(vecs[i]);
            send(vecs[i].nsend);
            idle(3);
            check_counts($sformatf("vec%0d", i), vecs[i].exp_ok, vecs[i].exp_bad);
            check_fields($sformatf("vec%0d", i), vecs[i]);
        end

        // Delete immediately followed by Add, valid_in never dropping
        clear_counts();
        build(vecs[2]);
        send(19);
        build(vecs[6]);
        send(36);
        idle(3);
        check_counts("b2b", 3'b101, 3'b000);
        check_fields("b2b_add", vecs[6]);
        check_fields("b2b_del", vecs[2]);

        // Reset landing on byte 10 of a Cancel
        clear_counts();
        build(vecs[1]);
        send(10);
        @(negedge clk);
        rst = 1'b1; valid_in = 1'b1; byte_in = msg[10];
        @(negedge clk);
        chk("rst_mid_outputs", 64'(|{add_internal_valid, add_packet_invalid, add_order_ref, add_side,
            add_shares, add_stock_symbol, add_price, cancel_internal_valid, cancel_packet_invalid,
            cancel_order_ref, cancel_canceled_shares, delete_internal_valid, delete_packet_invalid,
            delete_order_ref}), 64'd0);
        rst = 1'b0; valid_in = 1'b0; byte_in = 8'h00;
        idle(2);
        check_counts("rst_mid", 3'b000, 3'b000);
        clear_counts();
        v = vecs[1];
        v.ord = 64'hCAFEF00D12345678;
        v.shares = 32'h00BEEF01;
        build(v);
        send(23);
        idle(3);
        check_counts("post_rst", 3'b010, 3'b000);
        check_fields("post_rst", v);

        // Randomized messages, checked cycle by cycle against the model
        for (int k = 0; k < 60; k++) begin
            sel = $urandom_range(0, 3);
            v2.typ = (sel == 0) ? 8'h41 : (sel == 1) ? 8'h58 : (sel == 2) ? 8'h44 : 8'h00;
            if (sel == 3) begin
                do v2.typ = 8'($urandom); while (msglen(v2.typ) != 0 && v2.typ != 8'h00);
                while (msglen(v2.typ) != 0) v2.typ = 8'($urandom);
            end
            v2.ord    = {32'($urandom), 32'($urandom)};
            v2.side   = 1'($urandom);
            v2.shares = 32'($urandom);
            v2.stock  = {32'($urandom), 32'($urandom)};
            v2.price  = 32'($urandom);
            len = msglen(v2.typ);
            if (len == 0) begin
                v2.nsend = $urandom_range(1, 45);
                gap = $urandom_range(1, 2);
            end else if ($urandom_range(0, 3) == 0) begin
                v2.nsend = $urandom_range(1, len - 1);
                gap = $urandom_range(1, 2);
            end else begin
                v2.nsend = len;
                gap = $urandom_range(0, 2);
            end
            build(v2);
            send(v2.nsend);
            idle(gap);
        end
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
